mem_stage: RTL and testbench
============================

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have parameter BUS_TIMEOUT, default 255, meaning the number of cycles a bus access may wait for drready before it is aborted (legal range 2..65535).
REQ-002 SHALL have port clock, input, 1, meaning the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1, meaning the asynchronous active-low reset.
REQ-004 SHALL have port ex_valid, input, 1, meaning the execute stage presents an operation.
REQ-005 SHALL have port ex_ready, output, 1, meaning this stage accepts the operation this cycle.
REQ-006 SHALL have port ex_op, input, 4, meaning one of NONE, LB, LH, LW, LBU, LHU, SB, SH, SW.
REQ-007 SHALL have port ex_addr, input, 32, meaning the effective address, or the ALU result for NONE.
REQ-008 SHALL have port ex_wdata, input, 32, meaning the store data.
REQ-009 SHALL have port ex_rd, input, 5, meaning the destination register.
REQ-010 SHALL have ports daddr (output, 32), dvalid (output, 1), dwrite (output, 1), dwdata (output, 32), dwstb (output, 4), drready (input, 1) and drdata (input, 32), meaning the data-bus request and response.
REQ-011 SHALL have ports wb_valid (output, 1), wb_we (output, 1), wb_rd (output, 5) and wb_data (output, 32), meaning the registered result for the downstream memory/writeback pipeline register.
REQ-012 SHALL have ports bus_err (output, 1) and misalign (output, 1), meaning one-cycle fault pulses.

Function
REQ-013 SHALL implement the FSM states IDLE, BUS and RESP; ex_ready SHALL equal (state==IDLE).
REQ-014 SHALL, in IDLE with ex_valid=1 and op NONE, stay in IDLE and on the next edge drive wb_valid=1, wb_data=ex_addr, wb_rd=ex_rd and wb_we=(ex_rd!=0), giving one operation per cycle.
REQ-015 SHALL, in IDLE with ex_valid=1 and a memory op, latch op, addr, wdata and rd, then enter BUS and drive dvalid=1 from the next cycle.
REQ-016 SHALL drive daddr={addr[31:2],2'b00} and dwrite=1 for stores; daddr, dwrite, dwdata and dwstb SHALL be held stable while dvalid=1.
REQ-017 SHALL set the store lanes as follows: SB gives dwdata={4{wdata[7:0]}} and dwstb=4'b0001<<addr[1:0]; SH gives {2{wdata[15:0]}} and 4'b0011<<addr[1:0]; SW gives wdata and 4'b1111. Loads SHALL drive dwstb=0.
REQ-018 SHALL, in BUS, on the edge where drready=1, drop dvalid, capture drdata and enter RESP.
REQ-019 SHALL, in RESP, assert wb_valid for exactly one cycle and return to IDLE; loads SHALL have wb_we=(rd!=0), stores wb_we=0.
REQ-020 SHALL form load data from byte lane addr[1:0] (halfword lane addr[1]): LB and LH sign-extend; LBU and LHU zero-extend; LW passes drdata.
REQ-021 SHALL count cycles spent in BUS; when the count reaches BUS_TIMEOUT-1 with drready=0, it SHALL drop dvalid, pulse bus_err and enter RESP with wb_we=0 and wb_data=0.
REQ-022 SHALL ignore drready while dvalid=0.

Reset
REQ-023 SHALL, while reset=0, force state=IDLE, the counter=0 and all outputs to 0, except ex_ready=1 once in IDLE; a transaction in flight SHALL be abandoned with no wb_valid.

Configuration
REQ-024 SHALL, when MEM_STAGE_MISALIGN_TRAP_EN is defined, treat LH/LHU/SH with addr[0]=1 and LW/SW with addr[1:0]!=0 as faults: no bus access, a misalign pulse, and RESP with wb_we=0 and wb_data=addr.
REQ-025 SHALL, when MEM_STAGE_MISALIGN_TRAP_EN is undefined, drive misalign constant 0 and execute misaligned accesses at the lane given by clearing the unaligned low address bits.

Structure
REQ-026 SHALL place the op encoding enum, the state enum and the width constants in package mem_stage_pkg.
REQ-027 SHALL place load lane selection and extension in the combinational sub-module mem_load_align.

Verification
REQ-028 SHALL cover LB at addr 0x103 with drdata=0x80FF_FF11 -> wb_data=0xFFFF_FF80, wb_we=1, and wb_valid exactly one cycle.
REQ-029 SHALL cover SH at addr 0x202 with wdata=0x1234_ABCD -> daddr=0x200, dwstb=4'b1100 and dwdata=0xABCD_ABCD held until drready.
REQ-030 SHALL cover back-to-back NONE ops over 4 cycles -> 4 consecutive wb_valid beats with ex_ready constantly 1.
REQ-031 SHALL cover BUS_TIMEOUT=4 with drready held at 0 -> dvalid drops after 4 cycles, with one bus_err pulse and wb_we=0.
REQ-032 SHALL cover LW at addr 0x5 with the macro defined -> misalign pulse, dvalid never 1, and wb_data=0x5.
REQ-033 SHALL cover reset asserted in BUS -> dvalid=0 immediately and no wb_valid after reset release.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory stage: op encoding, FSM state encoding,
// bus/register widths and small op-classification helpers.
package mem_stage_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned REG_W  = 5;
  localparam int unsigned OP_W   = 4;
  localparam int unsigned STRB_W = 4;
  localparam int unsigned CNT_W  = 16;

  typedef enum logic [OP_W-1:0] {
    OP_NONE = 4'd0,
    OP_LB   = 4'd1,
    OP_LH   = 4'd2,
    OP_LW   = 4'd3,
    OP_LBU  = 4'd4,
    OP_LHU  = 4'd5,
    OP_SB   = 4'd6,
    OP_SH   = 4'd7,
    OP_SW   = 4'd8
  } mem_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  function automatic logic is_load(input mem_op_e op);
    return (op == OP_LB) || (op == OP_LH) || (op == OP_LW) ||
           (op == OP_LBU) || (op == OP_LHU);
  endfunction

  function automatic logic is_store(input mem_op_e op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

  // Halfword ops need addr[0]=0, word ops need addr[1:0]=0.
  function automatic logic is_misaligned(input mem_op_e op, input logic [1:0] lo);
    return (((op == OP_LH) || (op == OP_LHU) || (op == OP_SH)) && lo[0]) ||
           (((op == OP_LW) || (op == OP_SW)) && (lo != 2'b00));
  endfunction

endpackage

// File: rtl/mem_load_align.sv
// Load data alignment: selects the byte/halfword lane from the bus read word
// and sign- or zero-extends it according to the load op.
// Ports:
//   op    - load op being completed
//   lane  - low address bits of the access (byte lane; lane[1] = halfword lane)
//   rdata - raw read word from the data bus
//   data  - aligned, extended result
module mem_load_align
  import mem_stage_pkg::*;
(
  input  mem_op_e          op,
  input  logic [1:0]       lane,
  input  logic [XLEN-1:0]  rdata,
  output logic [XLEN-1:0]  data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = '0;
    case (lane)
      2'd0:    byte_sel = rdata[7:0];
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase
    // lane[0] is ignored for halfwords so misaligned halfwords use the aligned lane.
    half_sel = lane[1] ? rdata[31:16] : rdata[15:0];
  end

  always_comb begin
    data = '0;
    case (op)
      OP_LB:   data = {{24{byte_sel[7]}}, byte_sel};
      OP_LBU:  data = {24'h0, byte_sel};
      OP_LH:   data = {{16{half_sel[15]}}, half_sel};
      OP_LHU:  data = {16'h0, half_sel};
      OP_LW:   data = rdata;
      default: data = '0;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory pipeline stage: passes ALU results through in one cycle, performs
// loads/stores over a valid/ready data bus with a bounded wait, and registers
// the writeback result.
// Optional feature macro: MEM_STAGE_MISALIGN_TRAP_EN (trap misaligned
// halfword/word accesses instead of executing them at the aligned lane).
// Parameters:
//   BUS_TIMEOUT - cycles a bus access may wait for drready (2..65535)
// Ports:
//   clock, reset                      - clock, async active-low reset
//   ex_valid/ex_ready                 - handshake with the execute stage
//   ex_op, ex_addr, ex_wdata, ex_rd   - operation, address/ALU result, store data, dest reg
//   daddr, dvalid, dwrite, dwdata, dwstb, drready, drdata - data bus
//   wb_valid, wb_we, wb_rd, wb_data   - registered writeback result
//   bus_err, misalign                 - one-cycle fault pulses
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int unsigned BUS_TIMEOUT = 255
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                ex_valid,
  output logic                ex_ready,
  input  logic [OP_W-1:0]     ex_op,
  input  logic [XLEN-1:0]     ex_addr,
  input  logic [XLEN-1:0]     ex_wdata,
  input  logic [REG_W-1:0]    ex_rd,
  output logic [XLEN-1:0]     daddr,
  output logic                dvalid,
  output logic                dwrite,
  output logic [XLEN-1:0]     dwdata,
  output logic [STRB_W-1:0]   dwstb,
  input  logic                drready,
  input  logic [XLEN-1:0]     drdata,
  output logic                wb_valid,
  output logic                wb_we,
  output logic [REG_W-1:0]    wb_rd,
  output logic [XLEN-1:0]     wb_data,
  output logic                bus_err,
  output logic                misalign
);

  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(BUS_TIMEOUT - 1);

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  mem_op_e              op_in, op_q;
  logic [1:0]           lane_q;
  logic [REG_W-1:0]     rd_q;
  logic [XLEN-1:0]      daddr_q;
  logic                 dwrite_q;
  logic [XLEN-1:0]      dwdata_q;
  logic [STRB_W-1:0]    dwstb_q;
  logic                 wb_valid_q, wb_valid_d;
  logic                 wb_we_q, wb_we_d;
  logic [REG_W-1:0]     wb_rd_q, wb_rd_d;
  logic [XLEN-1:0]      wb_data_q, wb_data_d;
  logic                 bus_err_q, bus_err_d;
  logic                 accept_mem;
  logic                 trap;
  logic [XLEN-1:0]      st_data;
  logic [STRB_W-1:0]    st_strb;
  logic [XLEN-1:0]      load_data;

  assign op_in = mem_op_e'(ex_op);

`ifdef MEM_STAGE_MISALIGN_TRAP_EN
  logic misalign_q;

  assign trap = is_misaligned(op_in, ex_addr[1:0]);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) misalign_q <= 1'b0;
    else        misalign_q <= (state_q == ST_IDLE) && ex_valid && trap;
  end

  assign misalign = misalign_q;
`else
  assign trap     = 1'b0;
  assign misalign = 1'b0;
`endif

  // Store lane formation; the halfword shift uses only addr[1] so an
  // untrapped misaligned halfword lands on its aligned lane.
  always_comb begin
    st_data = '0;
    st_strb = '0;
    case (op_in)
      OP_SB: begin
        st_data = {4{ex_wdata[7:0]}};
        st_strb = 4'b0001 << ex_addr[1:0];
      end
      OP_SH: begin
        st_data = {2{ex_wdata[15:0]}};
        st_strb = 4'b0011 << {ex_addr[1], 1'b0};
      end
      OP_SW: begin
        st_data = ex_wdata;
        st_strb = 4'b1111;
      end
      default: ;
    endcase
  end

  mem_load_align u_align (
    .op    (op_q),
    .lane  (lane_q),
    .rdata (drdata),
    .data  (load_data)
  );

  // Writeback registers are loaded on the edge that enters RESP, so wb_valid
  // is high exactly during the RESP cycle (or the cycle after a NONE op).
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    accept_mem = 1'b0;
    wb_valid_d = 1'b0;
    wb_we_d    = 1'b0;
    wb_rd_d    = wb_rd_q;
    wb_data_d  = wb_data_q;
    bus_err_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ex_valid) begin
          if (is_load(op_in) || is_store(op_in)) begin
            if (trap) begin
              state_d    = ST_RESP;
              wb_valid_d = 1'b1;
              wb_rd_d    = ex_rd;
              wb_data_d  = ex_addr;
            end else begin
              state_d    = ST_BUS;
              cnt_d      = '0;
              accept_mem = 1'b1;
            end
          end else begin
            wb_valid_d = 1'b1;
            wb_we_d    = (ex_rd != '0);
            wb_rd_d    = ex_rd;
            wb_data_d  = ex_addr;
          end
        end
      end
      ST_BUS: begin
        if (drready) begin
          state_d    = ST_RESP;
          cnt_d      = '0;
          wb_valid_d = 1'b1;
          wb_rd_d    = rd_q;
          wb_we_d    = is_load(op_q) && (rd_q != '0);
          wb_data_d  = is_load(op_q) ? load_data : '0;
        end else if (cnt_q == TO_LAST) begin
          state_d    = ST_RESP;
          cnt_d      = '0;
          wb_valid_d = 1'b1;
          wb_rd_d    = rd_q;
          wb_data_d  = '0;
          bus_err_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      op_q       <= OP_NONE;
      lane_q     <= '0;
      rd_q       <= '0;
      daddr_q    <= '0;
      dwrite_q   <= 1'b0;
      dwdata_q   <= '0;
      dwstb_q    <= '0;
      wb_valid_q <= 1'b0;
      wb_we_q    <= 1'b0;
      wb_rd_q    <= '0;
      wb_data_q  <= '0;
      bus_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wb_valid_q <= wb_valid_d;
      wb_we_q    <= wb_we_d;
      wb_rd_q    <= wb_rd_d;
      wb_data_q  <= wb_data_d;
      bus_err_q  <= bus_err_d;
      if (accept_mem) begin
        op_q     <= op_in;
        lane_q   <= ex_addr[1:0];
        rd_q     <= ex_rd;
        daddr_q  <= {ex_addr[31:2], 2'b00};
        dwrite_q <= is_store(op_in);
        dwdata_q <= st_data;
        dwstb_q  <= st_strb;
      end
    end
  end

  assign ex_ready = (state_q == ST_IDLE);
  assign dvalid   = (state_q == ST_BUS);
  assign daddr    = daddr_q;
  assign dwrite   = dwrite_q;
  assign dwdata   = dwdata_q;
  assign dwstb    = dwstb_q;
  assign wb_valid = wb_valid_q;
  assign wb_we    = wb_we_q;
  assign wb_rd    = wb_rd_q;
  assign wb_data  = wb_data_q;
  assign bus_err  = bus_err_q;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: stimulus pushes expected bus requests and
// writeback beats into queues; negedge monitors pop and compare.
module tb_mem_stage;
  import mem_stage_pkg::*;

  typedef struct packed {
    logic        we;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        err;
    logic        mis;
    logic        chk_rd;
    logic        chk_data;
  } wb_exp_t;

  typedef struct packed {
    logic [31:0] addr;
    logic        wr;
    logic [31:0] wdata;
    logic [3:0]  strb;
  } bus_exp_t;

  logic        clock, reset;
  logic        ex_valid, ex_ready;
  logic [3:0]  ex_op;
  logic [31:0] ex_addr, ex_wdata;
  logic [4:0]  ex_rd;
  logic [31:0] daddr, dwdata, drdata;
  logic        dvalid, dwrite, drready;
  logic [3:0]  dwstb;
  logic        wb_valid, wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        bus_err, misalign;

  int compared   = 0;
  int mismatched = 0;

  wb_exp_t  wb_q[$];
  bus_exp_t bus_q[$];

  mem_stage #(.BUS_TIMEOUT(4)) dut (
    .clock    (clock),
    .reset    (reset),
    .ex_valid (ex_valid),
    .ex_ready (ex_ready),
    .ex_op    (ex_op),
    .ex_addr  (ex_addr),
    .ex_wdata (ex_wdata),
    .ex_rd    (ex_rd),
    .daddr    (daddr),
    .dvalid   (dvalid),
    .dwrite   (dwrite),
    .dwdata   (dwdata),
    .dwstb    (dwstb),
    .drready  (drready),
    .drdata   (drdata),
    .wb_valid (wb_valid),
    .wb_we    (wb_we),
    .wb_rd    (wb_rd),
    .wb_data  (wb_data),
    .bus_err  (bus_err),
    .misalign (misalign)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- writeback monitor ----------------
  always @(negedge clock) begin
    wb_exp_t e;
    if (wb_valid) begin
      compared++;
      if (wb_q.size() == 0) begin
        mismatched++;
        $display("FAIL wb_unexpected: got we=%0b rd=%0d data=0x%08h, required no beat", wb_we, wb_rd, wb_data);
      end else begin
        e = wb_q.pop_front();
        if (wb_we !== e.we || bus_err !== e.err || misalign !== e.mis ||
            (e.chk_rd && wb_rd !== e.rd) || (e.chk_data && wb_data !== e.data)) begin
          mismatched++;
          $display("FAIL wb_beat: got we=%0b rd=%0d data=0x%08h err=%0b mis=%0b, required we=%0b rd=%0d data=0x%08h err=%0b mis=%0b",
                   wb_we, wb_rd, wb_data, bus_err, misalign, e.we, e.rd, e.data, e.err, e.mis);
        end
      end
    end else if (bus_err || misalign) begin
      compared++;
      mismatched++;
      $display("FAIL stray_pulse: got bus_err=%0b misalign=%0b without wb_valid, required 0", bus_err, misalign);
    end
  end

  // ---------------- bus monitor ----------------
  logic        dv_prev = 1'b0;
  int          dv_len = 0;
  int          dv_len_last = 0;
  logic [31:0] h_addr, h_wdata;
  logic        h_wr;
  logic [3:0]  h_strb;

  always @(negedge clock) begin
    bus_exp_t b;
    if (dvalid) begin
      compared++;
      if (!dv_prev) begin
        dv_len = 1;
        h_addr = daddr; h_wr = dwrite; h_wdata = dwdata; h_strb = dwstb;
        if (bus_q.size() == 0) begin
          mismatched++;
          $display("FAIL bus_unexpected: got dvalid=1 daddr=0x%08h, required no request", daddr);
        end else begin
          b = bus_q.pop_front();
          if (daddr !== b.addr || dwrite !== b.wr || dwstb !== b.strb || (b.wr && dwdata !== b.wdata)) begin
            mismatched++;
            $display("FAIL bus_req: got addr=0x%08h wr=%0b wdata=0x%08h strb=%b, required addr=0x%08h wr=%0b wdata=0x%08h strb=%b",
                     daddr, dwrite, dwdata, dwstb, b.addr, b.wr, b.wdata, b.strb);
          end
        end
      end else begin
        dv_len++;
        if (daddr !== h_addr || dwrite !== h_wr || dwdata !== h_wdata || dwstb !== h_strb) begin
          mismatched++;
          $display("FAIL bus_hold: got addr=0x%08h wdata=0x%08h strb=%b, required held addr=0x%08h wdata=0x%08h strb=%b",
                   daddr, dwdata, dwstb, h_addr, h_wdata, h_strb);
        end
      end
    end else if (dv_prev) begin
      dv_len_last = dv_len;
    end
    dv_prev = dvalid;
  end

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
    end
  endtask

  task automatic exp_wb(input logic we, input logic [4:0] rd, input logic [31:0] data,
                        input logic err, input logic mis, input logic chk_rd, input logic chk_data);
    wb_exp_t e;
    e.we = we; e.rd = rd; e.data = data; e.err = err; e.mis = mis;
    e.chk_rd = chk_rd; e.chk_data = chk_data;
    wb_q.push_back(e);
  endtask

  task automatic exp_bus(input logic [31:0] addr, input logic wr, input logic [31:0] wdata, input logic [3:0] strb);
    bus_exp_t b;
    b.addr = addr; b.wr = wr; b.wdata = wdata; b.strb = strb;
    bus_q.push_back(b);
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wdata, input logic [4:0] rd);
    for (int n = 0; n < 50 && !ex_ready; n++) begin
      @(posedge clock); #1;
    end
    if (!ex_ready) begin
      compared++;
      mismatched++;
      $display("FAIL ex_ready_wait: got ex_ready=0 after 50 cycles, required 1");
    end
    ex_valid = 1'b1; ex_op = op; ex_addr = addr; ex_wdata = wdata; ex_rd = rd;
    @(posedge clock); #1;
    ex_valid = 1'b0; ex_op = 4'd0;
  endtask

  task automatic respond(input int wait_cycles, input logic [31:0] rdata);
    for (int n = 0; n < 20 && !dvalid; n++) begin
      @(posedge clock); #1;
    end
    if (!dvalid) begin
      compared++;
      mismatched++;
      $display("FAIL dvalid_wait: got dvalid=0 after 20 cycles, required 1");
    end
    repeat (wait_cycles) begin
      @(posedge clock); #1;
    end
    drready = 1'b1; drdata = rdata;
    @(posedge clock); #1;
    drready = 1'b0; drdata = 32'h0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int rd_tab[4];
    logic [31:0] a;
    rd_tab = '{1, 0, 7, 31};
    reset = 1'b0; ex_valid = 1'b0; ex_op = 4'd0; ex_addr = 32'h0; ex_wdata = 32'h0;
    ex_rd = 5'd0; drready = 1'b0; drdata = 32'h0;

    repeat (3) @(posedge clock);
    #1;
    chk("rst_ex_ready", {31'h0, ex_ready}, 32'h1);
    chk("rst_dvalid",   {31'h0, dvalid},   32'h0);
    chk("rst_wb_valid", {31'h0, wb_valid}, 32'h0);
    chk("rst_daddr",    daddr,             32'h0);
    chk("rst_dwstb",    {28'h0, dwstb},    32'h0);
    chk("rst_wb_data",  wb_data,           32'h0);
    chk("rst_pulses",   {30'h0, bus_err, misalign}, 32'h0);
    reset = 1'b1;
    @(posedge clock); #1;

    // LB at 0x103, byte lane 3 = 0x80, sign-extended
    exp_bus(32'h100, 1'b0, 32'h0, 4'b0000);
    exp_wb(1'b1, 5'd5, 32'hFFFF_FF80, 1'b0, 1'b0, 1'b1, 1'b1);
    issue(OP_LB, 32'h103, 32'h0, 5'd5);
    respond(0, 32'h80FF_FF11);

    // SH at 0x202: upper halfword lanes, held over two wait cycles
    exp_bus(32'h200, 1'b1, 32'hABCD_ABCD, 4'b1100);
    exp_wb(1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    issue(OP_SH, 32'h202, 32'h1234_ABCD, 5'd0);
    respond(2, 32'h0);

    // Back-to-back pass-through ops
    for (int i = 0; i < 4; i++) begin
      a = 32'h1000_0000 + 32'(i) * 32'h11;
      exp_wb(rd_tab[i] != 0, 5'(rd_tab[i]), a, 1'b0, 1'b0, 1'b1, 1'b1);
      issue(OP_NONE, a, 32'h0, 5'(rd_tab[i]));
      chk("b2b_ex_ready", {31'h0, ex_ready}, 32'h1);
    end

    // LBU lane 1 of 0x12345678 = 0x56
    exp_bus(32'h100, 1'b0, 32'h0, 4'b0000);
    exp_wb(1'b1, 5'd2, 32'h0000_0056, 1'b0, 1'b0, 1'b1, 1'b1);
    issue(OP_LBU, 32'h101, 32'h0, 5'd2);
    respond(1, 32'h1234_5678);

    // LH upper halfword 0x8001 sign-extended
    exp_bus(32'h100, 1'b0, 32'h0, 4'b0000);
    exp_wb(1'b1, 5'd4, 32'hFFFF_8001, 1'b0, 1'b0, 1'b1, 1'b1);
    issue(OP_LH, 32'h102, 32'h0, 5'd4);
    respond(1, 32'h8001_7FFF);

    // LHU lower halfword zero-extended
    exp_bus(32'h100, 1'b0, 32'h0, 4'b0000);
    exp_wb(1'b1, 5'd6, 32'h0000_F00D, 1'b0, 1'b0, 1'b1, 1'b1);
    issue(OP_LHU, 32'h100, 32'h0, 5'd6);
    respond(0, 32'h8001_F00D);

    // LW to x0: no register write
    exp_bus(32'h10, 1'b0, 32'h0, 4'b0000);
    exp_wb(1'b0, 5'd0, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b1, 1'b1);
    issue(OP_LW, 32'h10, 32'h0, 5'd0);
    respond(1, 32'hDEAD_BEEF);

    // SB lane 1
    exp_bus(32'h300, 1'b1, 32'hA5A5_A5A5, 4'b0010);
    exp_wb(1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    issue(OP_SB, 32'h301, 32'h0000_00A5, 5'd3);
    respond(1, 32'h0);

    // SW full word
    exp_bus(32'h404, 1'b1, 32'hCAFE_F00D, 4'b1111);
    exp_wb(1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    issue(OP_SW, 32'h404, 32'hCAFE_F00D, 5'd8);
    respond(0, 32'h0);

    // Timeout: drready never arrives, BUS_TIMEOUT=4
    exp_bus(32'h40, 1'b0, 32'h0, 4'b0000);
    exp_wb(1'b0, 5'd3, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1);
    issue(OP_LW, 32'h40, 32'h0, 5'd3);
    repeat (8) begin
      @(posedge clock); #1;
    end
    chk("timeout_dvalid_len", 32'(dv_len_last), 32'd4);

    // Misaligned LW at 0x5
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
    exp_wb(1'b0, 5'd9, 32'h5, 1'b0, 1'b1, 1'b0, 1'b1);
    issue(OP_LW, 32'h5, 32'h0, 5'd9);
    repeat (4) begin
      @(posedge clock); #1;
    end
`else
    exp_bus(32'h4, 1'b0, 32'h0, 4'b0000);
    exp_wb(1'b1, 5'd9, 32'h1122_3344, 1'b0, 1'b0, 1'b1, 1'b1);
    issue(OP_LW, 32'h5, 32'h0, 5'd9);
    respond(0, 32'h1122_3344);
`endif

    // Reset while in BUS: request abandoned, no writeback afterwards
    exp_bus(32'h500, 1'b0, 32'h0, 4'b0000);
    issue(OP_LW, 32'h500, 32'h0, 5'd11);
    @(negedge clock);
    #1;
    reset = 1'b0;
    #1;
    chk("rst_bus_dvalid",   {31'h0, dvalid},   32'h0);
    chk("rst_bus_ex_ready", {31'h0, ex_ready}, 32'h1);
    chk("rst_bus_wb_valid", {31'h0, wb_valid}, 32'h0);
    @(posedge clock); #1;
    reset = 1'b1;
    repeat (6) begin
      @(posedge clock); #1;
    end

    // Recovery: pass-through still works
    exp_wb(1'b1, 5'd12, 32'h0BAD_F00D, 1'b0, 1'b0, 1'b1, 1'b1);
    issue(OP_NONE, 32'h0BAD_F00D, 32'h0, 5'd12);

    repeat (6) begin
      @(posedge clock); #1;
    end
    chk("wb_queue_drained",  32'(wb_q.size()),  32'd0);
    chk("bus_queue_drained", 32'(bus_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
